// File: rtl/pit_capture_if.sv
// Bus bundle for pit_capture: control inputs, capture result and status outputs.
// The DUT takes the slave modport; the driver or host side takes master.
interface pit_capture_if #(
   parameter int unsigned COUNT_SIZE = 16
);
   logic                  capture_en;
   logic                  prescale_out;
   logic                  pulse_in;
   logic                  edge_sel;
   logic                  cap_flg_clr;
   logic                  ovf_flg_clr;
   logic [COUNT_SIZE-1:0] cap_value;
   logic                  cap_flag_o;
   logic                  ovr_flag_o;
   logic                  ovf_flag_o;
   logic                  irq_o;

   modport master (
      output capture_en, prescale_out, pulse_in, edge_sel, cap_flg_clr, ovf_flg_clr,
      input  cap_value, cap_flag_o, ovr_flag_o, ovf_flag_o, irq_o
   );

   modport slave (
      input  capture_en, prescale_out, pulse_in, edge_sel, cap_flg_clr, ovf_flg_clr,
      output cap_value, cap_flag_o, ovr_flag_o, ovf_flag_o, irq_o
   );
endinterface

// File: rtl/pit_capture.sv
// Pulse-interval capture timer: measures prescale ticks between successive
// selected edges of an asynchronous pulse train, with saturation and overrun flags.
module pit_capture #(
   parameter int unsigned COUNT_SIZE = 16
) (
   input logic         bus_clk,
   input logic         sync_reset,
   pit_capture_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StArmed, StMeasure} state_e;

   localparam logic [COUNT_SIZE-1:0] CntMax = '1;
   localparam logic [COUNT_SIZE-1:0] CntOne = COUNT_SIZE'(1);

   state_e                state_q, state_d;
   logic [COUNT_SIZE-1:0] counter_q, counter_d;
   logic [COUNT_SIZE-1:0] cap_value_q, cap_value_d;
   logic                  cap_flag_q, cap_flag_d;
   logic                  ovr_flag_q, ovr_flag_d;
   logic                  ovf_flag_q, ovf_flag_d;
   logic                  irq_q;
   logic                  s1_q, s2_q, s3_q;
   logic                  edge_hit;
   logic                  capture;
   logic                  sat_inc;
   logic [COUNT_SIZE-1:0] ps_term;

   // s1/s2 form the synchroniser; s3 is the previous s2 for edge detection.
   always_ff @(posedge bus_clk) begin
      if (sync_reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= bus.pulse_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign edge_hit = bus.edge_sel ? (s3_q & ~s2_q) : (s2_q & ~s3_q);
   assign ps_term  = bus.prescale_out ? CntOne : '0;

   always_comb begin
      state_d     = state_q;
      counter_d   = counter_q;
      cap_value_d = cap_value_q;
      capture     = 1'b0;
      sat_inc     = 1'b0;
      if (!bus.capture_en) begin
         state_d   = StIdle;
         counter_d = '0;
      end else begin
         unique case (state_q)
            StIdle:  state_d = StArmed;
            StArmed: if (edge_hit) state_d = StMeasure;
            StMeasure: begin
               sat_inc = bus.prescale_out && (counter_q == CntMax);
               if (edge_hit) begin
                  capture     = 1'b1;
                  counter_d   = '0;
                  // All-ones counter captures as all-ones instead of wrapping.
                  cap_value_d = sat_inc ? CntMax : counter_q + ps_term;
               end else if (bus.prescale_out && !sat_inc) begin
                  counter_d = counter_q + CntOne;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // A set in the same cycle as a clear wins, so no capture or overflow is lost.
   assign cap_flag_d = capture | (cap_flag_q & ~bus.cap_flg_clr);
   assign ovr_flag_d = ~bus.cap_flg_clr & (ovr_flag_q | (capture & cap_flag_q));
   assign ovf_flag_d = sat_inc | (ovf_flag_q & ~bus.ovf_flg_clr);

   always_ff @(posedge bus_clk) begin
      if (sync_reset) begin
         state_q     <= StIdle;
         counter_q   <= '0;
         cap_value_q <= '0;
         cap_flag_q  <= 1'b0;
         ovr_flag_q  <= 1'b0;
         ovf_flag_q  <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         cap_value_q <= cap_value_d;
         cap_flag_q  <= cap_flag_d;
         ovr_flag_q  <= ovr_flag_d;
         ovf_flag_q  <= ovf_flag_d;
         irq_q       <= capture;
      end
   end

   assign bus.cap_value  = cap_value_q;
   assign bus.cap_flag_o = cap_flag_q;
   assign bus.ovr_flag_o = ovr_flag_q;
   assign bus.ovf_flag_o = ovf_flag_q;
   assign bus.irq_o      = irq_q;
endmodule

// File: tb/tb_pit_capture.sv
// Bench for pit_capture: a 16-bit and a 4-bit instance share stimulus and are
// compared every cycle against an interval-measurement reference model.
module tb_pit_capture;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0, ps = 1'b0, pulse = 1'b0, esel = 1'b0, cclr = 1'b0, oclr = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   pit_capture_if #(.COUNT_SIZE(16)) bus16 ();
   pit_capture_if #(.COUNT_SIZE(4))  bus4 ();

   assign bus16.capture_en   = en;
   assign bus16.prescale_out = ps;
   assign bus16.pulse_in     = pulse;
   assign bus16.edge_sel     = esel;
   assign bus16.cap_flg_clr  = cclr;
   assign bus16.ovf_flg_clr  = oclr;
   assign bus4.capture_en    = en;
   assign bus4.prescale_out  = ps;
   assign bus4.pulse_in      = pulse;
   assign bus4.edge_sel      = esel;
   assign bus4.cap_flg_clr   = cclr;
   assign bus4.ovf_flg_clr   = oclr;

   pit_capture #(.COUNT_SIZE(16)) dut16 (.bus_clk(clk), .sync_reset(rst), .bus(bus16));
   pit_capture #(.COUNT_SIZE(4))  dut4  (.bus_clk(clk), .sync_reset(rst), .bus(bus4));

   // phase: 0 disabled/idle, 1 waiting for first edge, 2 measuring
   typedef struct {
      int       phase;
      longint   cnt;
      longint   val;
      bit       cf, of, vf, irq;
      bit [2:0] hist;
   } model_t;

   model_t m16, m4;

   function automatic model_t mstep(model_t m, longint maxv);
      model_t n = m;
      model_t z = '{default: 0};
      bit     e, sat;
      if (rst) return z;
      // hist[1] is the pulse sampled two clocks ago, hist[2] three clocks ago
      e      = esel ? (m.hist[2] & ~m.hist[1]) : (m.hist[1] & ~m.hist[2]);
      n.hist = {m.hist[1:0], pulse};
      n.irq  = 1'b0;
      sat    = en && m.phase == 2 && ps && m.cnt == maxv;
      if (!en) begin
         n.phase = 0;
         n.cnt   = 0;
      end else if (m.phase == 0) begin
         n.phase = 1;
      end else if (m.phase == 1) begin
         if (e) n.phase = 2;
      end else if (e) begin
         n.val = (m.cnt + longint'(ps) > maxv) ? maxv : m.cnt + longint'(ps);
         n.cnt = 0;
         n.irq = 1'b1;
      end else if (ps && m.cnt < maxv) begin
         n.cnt = m.cnt + 1;
      end
      n.cf = n.irq ? 1'b1 : (cclr ? 1'b0 : m.cf);
      n.of = cclr ? 1'b0 : ((n.irq && m.cf) ? 1'b1 : m.of);
      n.vf = sat ? 1'b1 : (oclr ? 1'b0 : m.vf);
      return n;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      m16 = mstep(m16, 65535);
      m4  = mstep(m4, 15);
      #1;
      check("cap_value16", 64'(bus16.cap_value), m16.val);
      check("cap_flag16", 64'(bus16.cap_flag_o), 64'(m16.cf));
      check("ovr_flag16", 64'(bus16.ovr_flag_o), 64'(m16.of));
      check("ovf_flag16", 64'(bus16.ovf_flag_o), 64'(m16.vf));
      check("irq16", 64'(bus16.irq_o), 64'(m16.irq));
      check("cap_value4", 64'(bus4.cap_value), m4.val);
      check("cap_flag4", 64'(bus4.cap_flag_o), 64'(m4.cf));
      check("ovr_flag4", 64'(bus4.ovr_flag_o), 64'(m4.of));
      check("ovf_flag4", 64'(bus4.ovf_flag_o), 64'(m4.vf));
      check("irq4", 64'(bus4.irq_o), 64'(m4.irq));
   endtask

   initial begin
      int ncap;
      m16 = '{default: 0};
      m4  = '{default: 0};

      // Reset with pulse held high: expect one arming edge after release.
      pulse = 1'b1;
      repeat (3) cycle();

      // Periodic interval: rising edges every 100 clocks, ps always high, no clears.
      rst = 1'b0; pulse = 1'b0; en = 1'b1; ps = 1'b1;
      repeat (10) cycle();
      ncap = 0;
      for (int p = 0; p < 5; p++) begin
         for (int j = 0; j < 100; j++) begin
            pulse = (j < 50);
            cycle();
            if (bus16.irq_o) begin
               ncap++;
               check("periodic_val", 64'(bus16.cap_value), 100);
            end
         end
      end
      pulse = 1'b0;
      repeat (10) begin
         cycle();
         if (bus16.irq_o) ncap++;
      end
      check("periodic_caps", ncap, 4);
      check("overrun_flag", 64'(bus16.ovr_flag_o), 1);
      check("sat_value4", 64'(bus4.cap_value), 15);
      check("sat_ovf4", 64'(bus4.ovf_flag_o), 1);
      cclr = 1'b1; oclr = 1'b1;
      cycle();
      cclr = 1'b0; oclr = 1'b0;
      check("clr_cap", 64'(bus16.cap_flag_o), 0);
      check("clr_ovr", 64'(bus16.ovr_flag_o), 0);

      // Falling-edge select, 30 high / 70 low, clear coincident with last capture.
      esel = 1'b1;
      ncap = 0;
      for (int p = 0; p < 4; p++) begin
         for (int j = 0; j < 100; j++) begin
            pulse = (j < 30);
            cclr  = (p == 3 && j == 32);
            cycle();
            if (bus16.irq_o) begin
               if (ncap > 0) check("fall_val", 64'(bus16.cap_value), 100);
               ncap++;
            end
            if (p == 3 && j == 32) begin
               check("simul_clr_cap", 64'(bus16.cap_flag_o), 1);
               check("simul_clr_ovr", 64'(bus16.ovr_flag_o), 0);
            end
         end
      end
      cclr = 1'b0;
      check("fall_caps", ncap, 4);

      // Reset in the middle of a measurement once the count reaches 57.
      esel = 1'b0; pulse = 1'b0;
      repeat (5) cycle();
      pulse = 1'b1;
      begin
         int guard = 0;
         while (m16.cnt != 57 && guard < 300) begin
            cycle();
            guard++;
         end
         check("reach57", 64'(guard < 300), 1);
      end
      rst = 1'b1;
      cycle();
      check("rst_val", 64'(bus16.cap_value), 0);
      check("rst_irq", 64'(bus16.irq_o), 0);
      rst = 1'b0;
      repeat (150) cycle();

      // Randomised operation.
      for (int i = 0; i < 4000; i++) begin
         ps   = ($urandom_range(3) == 0);
         if ($urandom_range(24) == 0) pulse = ~pulse;
         if ($urandom_range(400) == 0) esel = ~esel;
         cclr = ($urandom_range(15) == 0);
         oclr = ($urandom_range(40) == 0);
         if ($urandom_range(300) == 0) en = ~en;
         else if (!en && $urandom_range(10) == 0) en = 1'b1;
         rst  = ($urandom_range(700) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
